// File: rtl/select_pkg.sv
// Shared state encodings and the select-field width helper for the N-to-1 select pipe.
package select_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_t;

  // Width of a channel index: max(1, ceil(log2(m)))
  function automatic int unsigned sel_width(input int unsigned m);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << w) < m) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/select_nto1.sv
// Purely combinational N-bit channel selector; out-of-range indices map to the last channel.
module select_nto1
  import select_pkg::*;
#(
  parameter  int unsigned N  = 233,
  parameter  int unsigned M  = 3,
  localparam int unsigned SW = sel_width(M)
) (
  input  logic [M*N-1:0] in_bus,
  input  logic [SW-1:0]  sel,
  output logic [N-1:0]   data_c
);

  // Default to the last channel so any index >= M-1 lands there
  always_comb begin
    data_c = in_bus[(M-1)*N +: N];
    for (int unsigned k = 0; k < M - 1; k++) begin
      if (sel == SW'(k)) data_c = in_bus[k*N +: N];
    end
  end

endmodule

// File: rtl/select_pipe_nto1.sv
// N-to-1 operand select with a one-cycle registered output and a two-entry skid buffer.
module select_pipe_nto1
  import select_pkg::*;
#(
  parameter  int unsigned N  = 233,
  parameter  int unsigned M  = 3,
  localparam int unsigned SW = sel_width(M)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [M*N-1:0] IN_BUS,
  input  logic [SW-1:0]  SEL,
  input  logic           IN_VALID,
  output logic           IN_READY,
  output logic [N-1:0]   OUT,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic           SEL_ERR
);

  state_t         state;
  state_t         next_state;
  logic [N-1:0]   skid;
  logic [N-1:0]   sel_data_c;
  logic           sel_oor_c;
  logic           accept_c;
  logic           consume_c;
  logic           load_main_c;
  logic           load_skid_c;
  logic           main_from_skid_c;

  select_nto1 #(
    .N (N),
    .M (M)
  ) u_select (
    .in_bus (IN_BUS),
    .sel    (SEL),
    .data_c (sel_data_c)
  );

  assign sel_oor_c = ({1'b0, SEL} >= (SW+1)'(M));
  assign accept_c  = IN_VALID & IN_READY;
  assign consume_c = OUT_VALID & OUT_READY;

  // State register; handshake flags are flopped from next state so they carry no input paths
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= EMPTY;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
    end else begin
      state     <= next_state;
      IN_READY  <= (next_state != TWO);
      OUT_VALID <= (next_state != EMPTY);
    end
  end

  // Next-state decode from occupancy and the two handshakes
  always_comb begin
    next_state = state;
    unique case (state)
      EMPTY: if (accept_c) next_state = ONE;
      ONE: begin
        if (accept_c && !consume_c)      next_state = TWO;
        else if (!accept_c && consume_c) next_state = EMPTY;
      end
      TWO:     if (consume_c) next_state = ONE;
      default: next_state = EMPTY;
    endcase
  end

  // Datapath load controls per state
  always_comb begin
    load_main_c      = 1'b0;
    load_skid_c      = 1'b0;
    main_from_skid_c = 1'b0;
    unique case (state)
      EMPTY: load_main_c = accept_c;
      ONE: begin
        load_main_c = accept_c & consume_c;
        load_skid_c = accept_c & ~consume_c;
      end
      TWO:     main_from_skid_c = consume_c;
      default: ;
    endcase
  end

  // Main/skid storage and the sticky out-of-range flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT     <= '0;
      skid    <= '0;
      SEL_ERR <= 1'b0;
    end else begin
      if (load_main_c)           OUT  <= sel_data_c;
      else if (main_from_skid_c) OUT  <= skid;
      if (load_skid_c)           skid <= sel_data_c;
      if (accept_c && sel_oor_c) SEL_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_select_pipe_nto1.sv
// Bench for select_pipe_nto1: directed scenarios on N=233/M=3 plus random traffic on both configs.
module tb_select_pipe_nto1;

  localparam int unsigned AN = 233, AM = 3, ASW = 2;
  localparam int unsigned BN = 8, BM = 16, BSW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AM*AN-1:0] a_bus;
  logic [ASW-1:0]   a_sel;
  logic             a_iv, a_ir, a_ov, a_ordy, a_err;
  logic [AN-1:0]    a_out;

  logic [BM*BN-1:0] b_bus;
  logic [BSW-1:0]   b_sel;
  logic             b_iv, b_ir, b_ov, b_ordy, b_err;
  logic [BN-1:0]    b_out;

  select_pipe_nto1 #(.N(AN), .M(AM)) dut_a (
    .CLK(clk), .RST(rst), .IN_BUS(a_bus), .SEL(a_sel), .IN_VALID(a_iv),
    .IN_READY(a_ir), .OUT(a_out), .OUT_VALID(a_ov), .OUT_READY(a_ordy), .SEL_ERR(a_err));

  select_pipe_nto1 #(.N(BN), .M(BM)) dut_b (
    .CLK(clk), .RST(rst), .IN_BUS(b_bus), .SEL(b_sel), .IN_VALID(b_iv),
    .IN_READY(b_ir), .OUT(b_out), .OUT_VALID(b_ov), .OUT_READY(b_ordy), .SEL_ERR(b_err));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [232:0] got, input logic [232:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: an order-preserving FIFO of capacity two plus a sticky error bit
  logic [AN-1:0] qa[$];
  logic [BN-1:0] qb[$];
  logic          erra, errb;
  int            a_pops = 0;
  logic          acc_a, cons_a, acc_b, cons_b;
  int            ch_a, ch_b;

  always @(posedge clk) begin
    if (rst) begin
      qa.delete(); erra = 1'b0;
    end else begin
      acc_a  = a_iv && (qa.size() < 2);
      cons_a = (qa.size() > 0) && a_ordy;
      if (cons_a) begin void'(qa.pop_front()); a_pops++; end
      if (acc_a) begin
        ch_a = (a_sel >= AM) ? AM - 1 : int'(a_sel);
        qa.push_back(a_bus[ch_a*AN +: AN]);
        if (a_sel >= AM) erra = 1'b1;
      end
    end
    #1;
    check("a_in_ready", a_ir, qa.size() < 2);
    check("a_out_valid", a_ov, qa.size() > 0);
    check("a_sel_err", a_err, erra);
    if (qa.size() > 0) check("a_out", a_out, qa[0]);
  end

  always @(posedge clk) begin
    if (rst) begin
      qb.delete(); errb = 1'b0;
    end else begin
      acc_b  = b_iv && (qb.size() < 2);
      cons_b = (qb.size() > 0) && b_ordy;
      if (cons_b) void'(qb.pop_front());
      if (acc_b) begin
        ch_b = (b_sel >= BM) ? BM - 1 : int'(b_sel);
        qb.push_back(b_bus[ch_b*BN +: BN]);
        if (b_sel >= BM) errb = 1'b1;
      end
    end
    #1;
    check("b_in_ready", b_ir, qb.size() < 2);
    check("b_out_valid", b_ov, qb.size() > 0);
    check("b_sel_err", b_err, errb);
    if (qb.size() > 0) check("b_out", b_out, qb[0]);
  end

  function automatic logic [AN-1:0] rand_a();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[AN-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Randomise the whole bus, then place d on the channel the index selects
  task automatic a_drive(input logic iv, input logic [ASW-1:0] sel, input logic [AN-1:0] d,
                         input logic ordy);
    logic [703:0] t;
    int ch;
    for (int i = 0; i < 22; i++) t[i*32 +: 32] = $urandom;
    a_bus = t[AM*AN-1:0];
    ch = (sel >= AM) ? AM - 1 : int'(sel);
    a_bus[ch*AN +: AN] = d;
    a_sel  = sel;
    a_iv   = iv;
    a_ordy = ordy;
  endtask

  int p0;
  logic exp_ir;

  initial begin
    rst = 1'b1;
    a_bus = '0; a_sel = '0; a_iv = 1'b0; a_ordy = 1'b0;
    b_bus = '0; b_sel = '0; b_iv = 1'b0; b_ordy = 1'b0;
    repeat (2) step();
    check("a_out_in_reset", a_out, '0);
    rst = 1'b0;
    step();
    check("a_out_before_load", a_out, '0);
    check("b_out_before_load", b_out, '0);

    // Single beat, one-cycle latency
    a_drive(1'b1, 2'd1, 233'h1ABC, 1'b1);
    step();
    check("lat_valid", a_ov, 1'b1);
    check("lat_out", a_out, 233'h1ABC);
    check("lat_err", a_err, 1'b0);
    a_drive(1'b0, 2'd0, '0, 1'b1);
    step();

    // Out-of-range select maps to the last channel and sets the sticky flag
    a_drive(1'b1, 2'd3, 233'h55, 1'b1);
    step();
    check("oor_out", a_out, 233'h55);
    check("oor_err", a_err, 1'b1);
    a_drive(1'b1, 2'd0, 233'h77, 1'b1);
    step();
    check("after_oor_out", a_out, 233'h77);
    check("err_sticky", a_err, 1'b1);
    a_drive(1'b0, 2'd0, '0, 1'b1);
    step();

    // Stall: A and B fill the buffer, C waits at the input
    a_drive(1'b1, 2'd0, 233'hA, 1'b0); step();
    a_drive(1'b1, 2'd1, 233'hB, 1'b0); step();
    check("full_ready", a_ir, 1'b0);
    check("full_out_a", a_out, 233'hA);
    a_drive(1'b1, 2'd2, 233'hC, 1'b0); step();
    check("stall_out_a", a_out, 233'hA);
    a_ordy = 1'b1;
    #1 check("ready_no_comb", a_ir, 1'b0);
    a_ordy = 1'b0;
    step();
    check("stall_out_a2", a_out, 233'hA);
    a_drive(1'b1, 2'd2, 233'hC, 1'b1); step();
    check("drain_b", a_out, 233'hB);
    a_drive(1'b1, 2'd2, 233'hC, 1'b1); step();
    check("drain_c", a_out, 233'hC);
    a_drive(1'b0, 2'd0, '0, 1'b1); step();
    check("drain_empty", a_ov, 1'b0);

    // Sustained throughput
    p0 = a_pops;
    for (int i = 0; i < 100; i++) begin
      a_drive(1'b1, 2'($urandom_range(0, 2)), rand_a(), 1'b1);
      step();
    end
    a_drive(1'b0, 2'd0, '0, 1'b1);
    step();
    check("stream_pops", 233'(a_pops - p0), 233'd100);

    // Reset while full discards everything immediately
    a_drive(1'b1, 2'd0, 233'h111, 1'b0); step();
    a_drive(1'b1, 2'd1, 233'h222, 1'b0); step();
    check("pre_rst_ready", a_ir, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_valid", a_ov, 1'b0);
    check("rst_ready", a_ir, 1'b1);
    check("rst_out", a_out, '0);
    check("rst_err", a_err, 1'b0);
    step();
    rst = 1'b0;
    a_drive(1'b1, 2'd2, 233'h333, 1'b1);
    step();
    check("post_rst_out", a_out, 233'h333);
    a_drive(1'b0, 2'd0, '0, 1'b1);
    step();
    check("post_rst_alone", a_ov, 1'b0);

    // Random traffic on the wide config
    for (int i = 0; i < 2000; i++) begin
      a_drive(1'($urandom), 2'($urandom), rand_a(), 1'($urandom));
      step();
    end
    a_drive(1'b0, 2'd0, '0, 1'b0);

    // Random traffic on M=16, probing for an OUT_READY -> IN_READY path each cycle
    for (int i = 0; i < 10000; i++) begin
      for (int w = 0; w < 4; w++) b_bus[w*32 +: 32] = $urandom;
      b_sel  = 4'($urandom);
      b_iv   = 1'($urandom);
      b_ordy = 1'($urandom);
      exp_ir = (qb.size() < 2);
      b_ordy = ~b_ordy;
      #1 check("b_ready_comb", b_ir, exp_ir);
      b_ordy = ~b_ordy;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
